// File: rtl/calc_uart_tx.sv
// calc_uart_tx: sends the displayed value as four ASCII hex digits plus CR LF over UART 8N1.
module calc_uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int in_length = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [in_length-1:0] DATA,
    input  logic                 ERROR,
    output logic                 TX,
    output logic                 BUSY,
    output logic                 DONE
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int NCH  = in_length / 4 + 2;
    localparam int CNTW = $clog2(DIV);
    localparam int CW   = $clog2(NCH);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DIV - 1);
    localparam logic [CW-1:0]   LAST_CH = CW'(NCH - 1);
    localparam logic [CW-1:0]   CR_CH   = CW'(NCH - 2);
    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;
    state_t               state;
    logic [CNTW-1:0]      cnt;
    logic [2:0]           bit_idx;
    logic [CW-1:0]        char_idx;
    logic [in_length-1:0] data_q;
    logic                 err_q;
    logic [3:0]           nib;
    logic [7:0]           cur_byte;
    logic                 bit_end;
    always_comb begin
        nib      = 4'(data_q >> (in_length - 4 - 4 * int'(char_idx)));
        cur_byte = (char_idx == LAST_CH) ? 8'h0A :
                   (char_idx == CR_CH)   ? 8'h0D :
                   err_q                 ? 8'h45 :
                   (nib < 4'd10)         ? {4'h3, nib} : 8'h37 + {4'h0, nib};
        bit_end  = (cnt == CNT_MAX);
    end
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            TX       <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    state    <= START_BIT;
                    data_q   <= DATA;
                    err_q    <= ERROR;
                    char_idx <= '0;
                    cnt      <= '0;
                    TX       <= 1'b0;
                    BUSY     <= 1'b1;
                end
                START_BIT: if (bit_end) begin
                    state   <= DATA_BITS;
                    bit_idx <= '0;
                    cnt     <= '0;
                    TX      <= cur_byte[0];
                end else cnt <= cnt + 1'b1;
                DATA_BITS: if (bit_end) begin
                    cnt <= '0;
                    if (bit_idx == 3'd7) begin
                        state <= STOP_BIT;
                        TX    <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        TX      <= cur_byte[bit_idx + 3'd1];
                    end
                end else cnt <= cnt + 1'b1;
                STOP_BIT: if (bit_end) begin
                    cnt <= '0;
                    if (char_idx == LAST_CH) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        TX    <= 1'b1;
                    end else begin
                        char_idx <= char_idx + 1'b1;
                        state    <= START_BIT;
                        TX       <= 1'b0;
                    end
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
